// File: rtl/alu_decoder.sv
// RV32I ALU-control decoder behind a 2-entry elastic buffer (output + skid); 1-cycle latency, 1 instr/cycle.
// instr_ready = skid empty, purely registered. `ALU_DECODER_ILLEGAL_CNT_EN adds the saturating illegal_count port.
module alu_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        ctrl_valid,
  input  logic        ctrl_ready,
  output logic [3:0]  ctrl,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        illegal
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
  ,
  output logic [7:0]  illegal_count
`endif
);

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        use_imm;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  entry_t     dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // rs1 never influences the ALU control word
  logic unused_rs1;
  assign unused_rs1 = ^instr[19:15];

  always_comb begin
    dec = '{ctrl: CTRL_AND, use_imm: 1'b0, imm: 32'd0, illegal: 1'b1};
    unique case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000:  begin dec.ctrl = CTRL_ADD; dec.illegal = 1'b0; end
            3'b111:  begin dec.ctrl = CTRL_AND; dec.illegal = 1'b0; end
            3'b110:  begin dec.ctrl = CTRL_OR;  dec.illegal = 1'b0; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.ctrl    = CTRL_SUB;
          dec.illegal = 1'b0;
        end
      end
      7'b0010011: begin
        unique case (funct3)
          3'b000:  begin dec.ctrl = CTRL_ADD; dec.illegal = 1'b0; end
          3'b111:  begin dec.ctrl = CTRL_AND; dec.illegal = 1'b0; end
          3'b110:  begin dec.ctrl = CTRL_OR;  dec.illegal = 1'b0; end
          default: ;
        endcase
        if (!dec.illegal) begin
          dec.use_imm = 1'b1;
          dec.imm     = {{20{instr[31]}}, instr[31:20]};
        end
      end
      7'b0000011: begin
        dec = '{ctrl: CTRL_ADD, use_imm: 1'b1, imm: {{20{instr[31]}}, instr[31:20]}, illegal: 1'b0};
      end
      7'b0100011: begin
        dec = '{ctrl: CTRL_ADD, use_imm: 1'b1,
                imm: {{20{instr[31]}}, instr[31:25], instr[11:7]}, illegal: 1'b0};
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec.ctrl    = CTRL_SUB;
          dec.illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   accept;
  logic   deliver;

  assign instr_ready = !skid_vld_q;
  assign accept      = instr_valid && !skid_vld_q;
  assign deliver     = out_vld_q && ctrl_ready;

  // Output slot frees up: refill from skid first to keep order, else take the new word directly.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (!out_vld_q || deliver) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign ctrl_valid = out_vld_q;
  assign ctrl       = out_q.ctrl;
  assign use_imm    = out_q.use_imm;
  assign imm        = out_q.imm;
  assign illegal    = out_q.illegal;

`ifdef ALU_DECODER_ILLEGAL_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (deliver && out_q.illegal && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign illegal_count = cnt_q;
`endif

endmodule
